// File: rtl/wtr_write_arbiter.sv
// Round-robin arbiter that funnels several register-write sources into one registered write-back slot.
// Optional build macro WTR_SEL_CHECK_EN drops writes with out-of-range selects and raises a sticky sel_err.
module wtr_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [SEL_W*NUM_REQ-1:0]  req_sel,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wtr_stall,
    output logic                      wtr_en,
    output logic [SEL_W-1:0]          wtr_sel,
    output logic [DATA_W-1:0]         wtr_data,
    output logic [15:0]               write_count,
    output logic                      sel_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // valid/ready: a requester transfers on any edge where req_valid[i] & req_ready[i];
    // it holds valid/sel/data stable until then. req_ready depends on req_valid, never on itself.

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_any;
    logic               can_load;
    logic               transfer;
    logic               sel_ok;
    logic [SEL_W-1:0]   grant_sel;
    logic [DATA_W-1:0]  grant_data;
    int                 scan_idx;

    assign can_load = !wtr_en || !wtr_stall;

    // Search starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_any && req_valid[scan_idx[PTR_W-1:0]]) begin
                grant_any                       = 1'b1;
                grant_idx                       = scan_idx[PTR_W-1:0];
                grant_oh[scan_idx[PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    assign req_ready  = (rst_n && can_load) ? grant_oh : '0;
    assign transfer   = |req_ready;
    assign grant_sel  = req_sel[int'(grant_idx)*SEL_W +: SEL_W];
    assign grant_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

`ifdef WTR_SEL_CHECK_EN
    assign sel_ok = (int'(grant_sel) >= 1) && (int'(grant_sel) <= 14);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (transfer && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_ok  = 1'b1;
    assign sel_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wtr_en      <= 1'b0;
            wtr_sel     <= '0;
            wtr_data    <= '0;
            write_count <= '0;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
        end else begin
            if (wtr_en && !wtr_stall) begin
                write_count <= write_count + 16'd1;
            end
            if (transfer) begin
                rr_ptr <= grant_idx;
            end
            // sel/data keep their last values when the slot empties.
            if (can_load) begin
                wtr_en <= transfer && sel_ok;
                if (transfer && sel_ok) begin
                    wtr_sel  <= grant_sel;
                    wtr_data <= grant_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wtr_write_arbiter.sv
// Scoreboard bench for wtr_write_arbiter: directed scenarios then randomized traffic with stalls.
module tb_wtr_write_arbiter;

    localparam int N  = 3;
    localparam int SW = 5;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [SW*N-1:0] req_sel = '0;
    logic [DW*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wtr_stall = 1'b0;
    logic            wtr_en;
    logic [SW-1:0]   wtr_sel;
    logic [DW-1:0]   wtr_data;
    logic [15:0]     write_count;
    logic            sel_err;

    wtr_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
        .req_data(req_data), .req_ready(req_ready), .wtr_stall(wtr_stall),
        .wtr_en(wtr_en), .wtr_sel(wtr_sel), .wtr_data(wtr_data),
        .write_count(write_count), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [SW+DW-1:0] exp_q[$];
    logic             m_en = 1'b0;
    int               m_last = N - 1;
    logic [15:0]      m_cnt = '0;
    logic             m_err = 1'b0;
    logic [N-1:0]     granted_mask = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit sel_valid(input logic [SW-1:0] s);
`ifdef WTR_SEL_CHECK_EN
        return (s >= 5'd1) && (s <= 5'd14);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_en = 1'b0;
        m_last = N - 1;
        m_cnt = '0;
        m_err = 1'b0;
        granted_mask = '0;
    endtask

    // Reference model: round-robin rotation after the last winner, one-entry write slot.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         cl;
        int           g;
        if (!rst_n) begin
            check("rst_ready", req_ready, 0);
            check("rst_en", wtr_en, 0);
            check("rst_sel", wtr_sel, 0);
            check("rst_data", wtr_data, 0);
            check("rst_count", write_count, 0);
            check("rst_err", sel_err, 0);
        end else begin
            exp_ready = '0;
            g = 0;
            cl = !m_en || !wtr_stall;
            check("wtr_en", wtr_en, m_en);
            check("write_count", write_count, m_cnt);
            check("sel_err", sel_err, m_err);
            if (cl) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (exp_ready == 0 && req_valid[idx]) begin
                        exp_ready[idx] = 1'b1;
                        g = idx;
                    end
                end
            end
            check("req_ready", req_ready, exp_ready);
            if (m_en && !wtr_stall) m_cnt = m_cnt + 16'd1;
            granted_mask = exp_ready;
            if (cl) begin
                if (exp_ready != 0) begin
                    logic [SW-1:0] s;
                    logic [DW-1:0] d;
                    s = req_sel[g*SW +: SW];
                    d = req_data[g*DW +: DW];
                    m_last = g;
                    if (sel_valid(s)) begin
                        exp_q.push_back({s, d});
                        m_en = 1'b1;
                    end else begin
                        m_en = 1'b0;
                        m_err = 1'b1;
                    end
                end else begin
                    m_en = 1'b0;
                end
            end
        end
    end

    // Monitor: every retiring write must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n && wtr_en && !wtr_stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                logic [SW+DW-1:0] e;
                e = exp_q.pop_front();
                check("wtr_sel", wtr_sel, e[SW+DW-1:DW]);
                check("wtr_data", wtr_data, e[DW-1:0]);
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [SW-1:0] s0, s1, s2,
                         input logic [DW-1:0] d0, d1, d2, input logic st);
        @(posedge clk);
        #1;
        req_valid = v;
        req_sel   = {s2, s1, s0};
        req_data  = {d2, d1, d0};
        wtr_stall = st;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive('0, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        wtr_stall = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [N-1:0] seq2 [6];

    initial begin
        seq2[0] = 3'b001; seq2[1] = 3'b010; seq2[2] = 3'b100;
        seq2[3] = 3'b001; seq2[4] = 3'b010; seq2[5] = 3'b100;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single write from requester 1
        drive(3'b010, 0, 8, 0, 0, 16'h1234, 0, 1'b0);
        check("t1_ready", req_ready, 3'b010);
        idle();
        check("t1_en", wtr_en, 1);
        check("t1_sel", wtr_sel, 8);
        check("t1_data", wtr_data, 16'h1234);
        check("t1_count0", write_count, 0);
        idle();
        check("t1_count1", write_count, 1);

        // continuous contention rotates 0,1,2
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 1, 2, 3, 16'h0011, 16'h0022, 16'h0033, 1'b0);
            check("t2_grant", req_ready, seq2[i]);
        end

        // stall holds the slot and blocks grants
        drive(3'b001, 4, 0, 0, 16'hC0DE, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 4, 0, 0, 16'hC0DE, 0, 0, 1'b1);
            check("t3_ready", req_ready, 0);
            check("t3_sel", wtr_sel, 4);
            check("t3_data", wtr_data, 16'hC0DE);
        end
        drive(3'b001, 4, 0, 0, 16'hC0DE, 0, 0, 1'b0);
        check("t3_regrant", req_ready, 3'b001);
        idle();

        // same destination from two requesters
        do_reset();
        drive(3'b101, 6, 0, 6, 16'hAAAA, 0, 16'hBBBB, 1'b0);
        check("t4_first", req_ready, 3'b001);
        drive(3'b100, 6, 0, 6, 16'hAAAA, 0, 16'hBBBB, 1'b0);
        check("t4_second", req_ready, 3'b100);
        check("t4_data_a", wtr_data, 16'hAAAA);
        idle();
        check("t4_data_b", wtr_data, 16'hBBBB);
        idle();

        // asynchronous reset during a burst
        for (int i = 0; i < 3; i++) drive(3'b111, 1, 2, 3, 16'h0101, 16'h0202, 16'h0303, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req_valid = '0;
        model_clear();
        #1;
        check("t5_en_async", wtr_en, 0);
        check("t5_ready_async", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 3'b111;
        @(negedge clk);
        #1;
        check("t5_first_win", req_ready, 3'b001);
        idle();
        idle();

        // out-of-range select
        drive(3'b010, 0, 15, 0, 0, 16'h5A5A, 0, 1'b0);
        check("t6_ready", req_ready, 3'b010);
        idle();
`ifdef WTR_SEL_CHECK_EN
        check("t6_en", wtr_en, 0);
        check("t6_err", sel_err, 1);
`else
        check("t6_en", wtr_en, 1);
        check("t6_sel", wtr_sel, 15);
        check("t6_err", sel_err, 0);
`endif
        idle();

        // randomized traffic; a requester only changes its request after being granted
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (granted_mask[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_sel[i*SW +: SW] = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(0, 31))
                                                                      : SW'($urandom_range(1, 14));
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            wtr_stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            #1;
        end

        repeat (4) idle();
        check("drain_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wtr_write_arbiter.md
Name: wtr_write_arbiter

Overview:
Shares the single register-write port between several write sources: control unit immediates, ALU result and memory load data. Each requester presents a destination register code and data. The block grants one requester per cycle in round-robin order and drives a registered write-back stage. That stage provides WTR_sel/WTR_en to the write-to-register decoder and the data onto the shared write bus. It also counts issued writes for debug.

Parameters:
NUM_REQ, 3, number of write requesters (2..8); index 0 = control unit, 1 = ALU, 2 = memory
DATA_W, 16, register write data width
SEL_W, 5, register select width; matches the decoder select input

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_sel  input  SEL_W*NUM_REQ  packed destination codes; requester i occupies bits [i*SEL_W +: SEL_W]
req_data  input  DATA_W*NUM_REQ  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
wtr_stall  input  1  datapath cannot accept a write this cycle
wtr_en  output  1  write strobe to the decoder enable
wtr_sel  output  SEL_W  register code to the decoder select
wtr_data  output  DATA_W  data on the shared write bus
write_count  output  16  number of writes issued, wraps
sel_err  output  1  sticky invalid-select flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): wtr_en=0, wtr_sel=0, wtr_data=0, write_count=0, sel_err=0, rr_ptr=NUM_REQ-1. req_ready is forced to 0 while reset is asserted. Reset mid-operation discards any held write.
- Output stage: one register slot {wtr_en, wtr_sel, wtr_data}.
- Slot may load when wtr_en=0 or wtr_stall=0 (can_load).
- Grant is combinational.
  - If can_load=0: req_ready=0.
  - Otherwise: req_ready has one bit set, for the first valid requester searching from rr_ptr+1 upward, modulo NUM_REQ.
  - If no requester is valid: req_ready=0.
- req_ready never depends on itself. It does depend on req_valid, so requesters must not derive req_valid from req_ready.
- On a transfer from requester g at edge k:
  - slot loads req_sel[g] and req_data[g]; wtr_en=1 in cycle k+1
  - rr_ptr <= g
  - latency is exactly 1 cycle
- No transfer and can_load=1: wtr_en <= 0 next cycle; sel and data hold their last values.
- Stall: while wtr_en=1 and wtr_stall=1, wtr_en/wtr_sel/wtr_data hold and no grant is issued. Each accepted write produces exactly one wtr_en cycle with wtr_stall=0.
- Throughput: one write per cycle with no stall. Back-to-back grants to different requesters are allowed.
- write_count increments on every cycle with wtr_en=1 & wtr_stall=0, wrapping 16'hFFFF to 0.
- Same destination from two requesters in the same cycle: only the granted one transfers; the other waits. Writes reach the decoder in grant order.
- A requester must hold req_valid, req_sel and req_data stable until it is granted.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.

Optional Feature:
Macro WTR_SEL_CHECK_EN.
- Defined:
  - valid codes are 1..14
  - a granted request with sel 0 or 15..31 is accepted (ready, rr_ptr advances) but does not load the slot, so wtr_en stays 0
  - sel_err sets to 1 and stays until reset
  - write_count does not increment for such a request
- Not defined:
  - every code passes through unchanged; an out-of-range code reaches the decoder, which outputs no strobe
  - sel_err is tied to 0

Test Plan:
1. Reset, then req_valid=3'b010 with sel=8, data=16'h1234 for 1 cycle -> req_ready=3'b010 the same cycle. Next cycle: wtr_en=1, wtr_sel=8, wtr_data=16'h1234. write_count goes to 1 after the following edge.
2. req_valid=3'b111 held continuously, with sels 1/2/3 -> grant sequence 0,1,2,0,1,2. wtr_en is high every cycle from the second cycle and wtr_sel runs 1,2,3,1,2,3.
3. Write pending with wtr_stall=1 for 3 cycles while req_valid=3'b001 -> wtr_en/wtr_sel/wtr_data stable and req_ready=0 for those 3 cycles. After stall drops, the held write completes and requester 0 is granted in that same cycle.
4. Requesters 0 and 2 both target sel 6, with data AAAA and BBBB -> two separate wtr_en cycles. The first carries AAAA (requester 0 is granted first after reset) and the next carries BBBB.
5. Assert rst_n=0 mid-burst while wtr_en=1 -> wtr_en drops immediately without waiting for a clock edge. After release, rr_ptr restarts and requester 0 wins the first contention.
6. With WTR_SEL_CHECK_EN defined, requester 1 sends sel 15 -> it is granted, wtr_en stays 0, sel_err=1 and write_count is unchanged. Without the macro: wtr_en=1, wtr_sel=15, sel_err=0.
